// File: rtl/program_store_pkg.sv
//==============================================================================
// Module      : program_store_pkg
// Description : Shared types and constants for the CPU program store.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package program_store_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LD_HI   = 2'd1,
    LD_LO   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int         PROG_DEPTH = 16;
  localparam logic [7:0] NOP        = 8'h00;

  // Ramen-timer program the chip runs when nothing has been loaded.
  localparam logic [7:0] DEFAULT_PROG [PROG_DEPTH] = '{
    8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
    8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF
  };

  function automatic logic [7:0] make_instr(input logic [3:0] hi, input logic [3:0] lo);
    return {hi, lo};
  endfunction

endpackage

`default_nettype wire

// File: rtl/program_store_if.sv
//==============================================================================
// Module      : program_store_if
// Description : CPU fetch bus and program-load pins of the program store.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface program_store_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic [7:0]        instr;
  logic              load_mode;
  logic [3:0]        nib_in;
  logic              nib_stb;
  logic              cpu_n_reset;
  logic [ADDR_W-1:0] wr_ptr;
  logic              busy;

  modport master (
    output address, load_mode, nib_in, nib_stb,
    input  instr, cpu_n_reset, wr_ptr, busy
  );

  modport slave (
    input  address, load_mode, nib_in, nib_stb,
    output instr, cpu_n_reset, wr_ptr, busy
  );
endinterface

`default_nettype wire

// File: rtl/program_store_pin_sync.sv
//==============================================================================
// Module      : pin_sync
// Description : Multi-flop synchronizer for a bus of asynchronous pins.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pin_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int W           = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic [W-1:0] i_async,
  output logic      [W-1:0] o_sync
);

  logic [W-1:0] r_stage [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_sync = r_stage[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/program_store.sv
//==============================================================================
// Module      : program_store
// Description : 16x8 writable program memory for the 4-bit CPU, loaded in
//               system from nibble pins while the CPU is held in reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module program_store
  import program_store_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  program_store_if.slave    bus
);

  logic [5:0]        w_pins;
  logic              w_ld_s;
  logic              w_stb_s;
  logic [3:0]        w_nib_s;
  logic              r_ld_prev;
  logic              r_stb_prev;
  logic              w_ld_rise;
  logic              w_stb_edge;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_wr_en;
  logic              w_hi_cap;
  logic              w_ptr_clr;

  logic [3:0]        r_hi_nib;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_cpu_n_reset;
  logic [7:0]        r_mem [DEPTH];

  pin_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .W           (6)
  ) u_pin_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async ({bus.load_mode, bus.nib_stb, bus.nib_in}),
    .o_sync  (w_pins)
  );

  assign w_ld_s     = w_pins[5];
  assign w_stb_s    = w_pins[4];
  assign w_nib_s    = w_pins[3:0];
  assign w_ld_rise  = w_ld_s & ~r_ld_prev;
  assign w_stb_edge = w_stb_s & ~r_stb_prev;

  // A falling load_mode always wins over a strobe seen in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    w_hi_cap     = 1'b0;
    w_ptr_clr    = 1'b0;
    case (r_state)
      RUN: begin
        if (w_ld_rise) begin
          w_state_next = LD_HI;
          w_ptr_clr    = 1'b1;
        end
      end
      LD_HI: begin
        if (!w_ld_s) begin
          w_state_next = RELEASE;
        end else if (w_stb_edge) begin
          w_hi_cap     = 1'b1;
          w_state_next = LD_LO;
        end
      end
      LD_LO: begin
        if (!w_ld_s) begin
          w_state_next = RELEASE;
        end else if (w_stb_edge) begin
          w_wr_en      = 1'b1;
          w_state_next = LD_HI;
        end
      end
      RELEASE: w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RELEASE;
      r_ld_prev     <= 1'b0;
      r_stb_prev    <= 1'b0;
      r_hi_nib      <= 4'h0;
      r_wr_ptr      <= '0;
      r_cpu_n_reset <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_ld_prev     <= w_ld_s;
      r_stb_prev    <= w_stb_s;
      // Registered from next state so the CPU leaves reset on the edge entering RUN.
      r_cpu_n_reset <= (w_state_next == RUN);
      if (w_hi_cap) r_hi_nib <= w_nib_s;
      if (w_ptr_clr) begin
        r_wr_ptr <= '0;
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= DEFAULT_PROG[i];
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr] <= make_instr(r_hi_nib, w_nib_s);
    end
  end

  assign bus.instr       = (r_state == RUN) ? r_mem[bus.address] : NOP;
  assign bus.cpu_n_reset = r_cpu_n_reset;
  assign bus.wr_ptr      = r_wr_ptr;
  assign bus.busy        = (r_state != RUN);

endmodule

`default_nettype wire

// File: tb/tb_program_store.sv
//==============================================================================
// Module      : tb_program_store
// Description : Scoreboard testbench for the program store.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_program_store;

  localparam int SEL_INSTR = 0;
  localparam int SEL_WPTR  = 1;
  localparam int SEL_NRST  = 2;
  localparam int SEL_BUSY  = 3;

  typedef struct {
    int         sel;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q [$];
  int   n_tests;
  int   n_fail;

  logic [7:0] c_default [16] = '{
    8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
    8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF
  };

  program_store_if #(.ADDR_W(4)) bus ();

  program_store #(
    .DEPTH       (16),
    .ADDR_W      (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: drains every expectation posted in the current cycle at negedge.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        SEL_INSTR: act = bus.instr;
        SEL_WPTR:  act = {4'h0, bus.wr_ptr};
        SEL_NRST:  act = {7'h0, bus.cpu_n_reset};
        default:   act = {7'h0, bus.busy};
      endcase
      n_tests++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  function automatic void expect_sig(input int sel, input logic [7:0] val, input string name);
    exp_t e;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_mem(input logic [3:0] addr, input logic [7:0] val, input string name);
    bus.address = addr;
    expect_sig(SEL_INSTR, val, name);
    tick(1);
  endtask

  task automatic send_nib(input logic [3:0] n, input int hold);
    bus.nib_in  = n;
    bus.nib_stb = 1'b1;
    tick(hold);
    bus.nib_stb = 1'b0;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4], 4);
    send_nib(b[3:0], 4);
  endtask

  task automatic load_begin();
    bus.load_mode = 1'b1;
    tick(5);
  endtask

  task automatic load_end();
    bus.load_mode = 1'b0;
    tick(6);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.address   = 4'h0;
    bus.load_mode = 1'b0;
    bus.nib_in    = 4'h0;
    bus.nib_stb   = 1'b0;
    tick(2);

    // Reset state and release
    expect_sig(SEL_NRST,  8'h00, "rst_nrst");
    expect_sig(SEL_BUSY,  8'h01, "rst_busy");
    expect_sig(SEL_INSTR, 8'h00, "rst_instr");
    expect_sig(SEL_WPTR,  8'h00, "rst_wptr");
    tick(1);
    rst = 1'b0;
    expect_sig(SEL_NRST, 8'h00, "rel_nrst_first");
    expect_sig(SEL_BUSY, 8'h01, "rel_busy_first");
    tick(1);
    expect_sig(SEL_NRST, 8'h01, "run_nrst");
    expect_sig(SEL_BUSY, 8'h00, "run_busy");
    chk_mem(4'd0,  8'hB7, "default_0");
    chk_mem(4'd15, 8'hFF, "default_15");

    // Two-word load
    bus.load_mode = 1'b1;
    tick(2);
    expect_sig(SEL_NRST, 8'h01, "load_nrst_early");
    tick(2);
    expect_sig(SEL_NRST,  8'h00, "load_nrst_held");
    expect_sig(SEL_BUSY,  8'h01, "load_busy");
    expect_sig(SEL_INSTR, 8'h00, "load_instr_nop");
    tick(1);
    send_nib(4'hB, 4);
    send_nib(4'h3, 4);
    send_nib(4'h0, 4);
    send_nib(4'h1, 4);
    bus.load_mode = 1'b0;
    tick(3);
    expect_sig(SEL_NRST, 8'h00, "release_nrst");
    expect_sig(SEL_BUSY, 8'h01, "release_busy");
    tick(1);
    expect_sig(SEL_NRST, 8'h01, "after_release_nrst");
    expect_sig(SEL_WPTR, 8'h02, "two_word_wptr");
    tick(1);
    chk_mem(4'd0, 8'hB3, "two_word_m0");
    chk_mem(4'd1, 8'h01, "two_word_m1");
    chk_mem(4'd2, 8'hE1, "two_word_m2");

    // Odd nibble count
    load_begin();
    send_nib(4'hA, 4);
    send_nib(4'h5, 4);
    send_nib(4'hC, 4);
    load_end();
    expect_sig(SEL_WPTR, 8'h01, "odd_wptr");
    chk_mem(4'd0, 8'hA5, "odd_m0");
    chk_mem(4'd1, 8'h01, "odd_m1");

    // Wrap: 17 bytes
    load_begin();
    for (int i = 0; i < 17; i++) send_byte(8'(8'h10 + i));
    load_end();
    expect_sig(SEL_WPTR, 8'h01, "wrap_wptr");
    chk_mem(4'd0,  8'h20, "wrap_m0");
    chk_mem(4'd1,  8'h11, "wrap_m1");
    chk_mem(4'd15, 8'h1F, "wrap_m15");

    // Long strobe captures one nibble
    load_begin();
    send_nib(4'h7, 10);
    send_nib(4'h2, 4);
    load_end();
    expect_sig(SEL_WPTR, 8'h01, "long_stb_wptr");
    chk_mem(4'd0, 8'h72, "long_stb_m0");
    chk_mem(4'd1, 8'h11, "long_stb_m1");

    // Strobe and load_mode fall together in LD_LO
    load_begin();
    send_nib(4'hE, 4);
    bus.nib_in    = 4'hD;
    bus.nib_stb   = 1'b1;
    bus.load_mode = 1'b0;
    tick(3);
    expect_sig(SEL_BUSY, 8'h01, "tie_release_busy");
    tick(3);
    bus.nib_stb = 1'b0;
    tick(2);
    expect_sig(SEL_WPTR, 8'h00, "tie_wptr");
    chk_mem(4'd0, 8'h72, "tie_m0");

    // Reset mid-load after three bytes
    load_begin();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_nib(4'h4, 4);
    rst           = 1'b1;
    bus.load_mode = 1'b0;
    expect_sig(SEL_NRST, 8'h00, "abort_nrst");
    expect_sig(SEL_BUSY, 8'h01, "abort_busy");
    expect_sig(SEL_WPTR, 8'h00, "abort_wptr");
    tick(1);
    bus.address = 4'd0;
    expect_sig(SEL_INSTR, 8'h00, "abort_instr");
    tick(1);
    rst = 1'b0;
    tick(2);
    expect_sig(SEL_WPTR, 8'h00, "restored_wptr");
    for (int i = 0; i < 16; i++) chk_mem(4'(i), c_default[i], $sformatf("restored_m%0d", i));

    tick(2);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
